// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: widths, ALU op codes,
// multiplier FSM states and the operand forwarding helper.
package ex_stage_pkg;

   localparam int DATA_W  = 32;
   localparam int MUL_CYC = 32;
   localparam int CNT_W   = $clog2(MUL_CYC);

   typedef enum logic [3:0] {
      ALU_AND  = 4'd0,
      ALU_OR   = 4'd1,
      ALU_ADD  = 4'd2,
      ALU_SUB  = 4'd3,
      ALU_SLT  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_XOR  = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9,
      ALU_MULT = 4'd10,
      ALU_LUI  = 4'd11
   } alu_op_e;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_BUSY = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_e;

   // The younger producer (EX/MEM) wins over MEM/WB; r0 never forwards.
   function automatic logic [DATA_W-1:0] fwd_pick(
      input logic [4:0]        src,
      input logic [DATA_W-1:0] rf,
      input logic              mem_en,
      input logic [4:0]        mem_addr,
      input logic [DATA_W-1:0] mem_data,
      input logic              wb_en,
      input logic [4:0]        wb_addr,
      input logic [DATA_W-1:0] wb_data
   );
      priority case (1'b1)
         mem_en && mem_addr != 5'd0 && mem_addr == src:
            fwd_pick = mem_data;
         wb_en && wb_addr != 5'd0 && wb_addr == src:
            fwd_pick = wb_data;
         default:
            fwd_pick = rf;
      endcase
   endfunction

endpackage

// File: rtl/ex_stage_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle,
// low DATA_W bits of a*b available while in DONE.
module ex_stage_mul_iter
   import ex_stage_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   output logic              idle,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] product
);

   mul_state_e        state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         MUL_IDLE: begin
            if (start) begin
               a_d     = a_in;
               b_d     = b_in;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = MUL_BUSY;
            end
         end
         MUL_BUSY: begin
            if (b_q[0]) acc_d = acc_q + a_q;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(MUL_CYC - 1))
               state_d = MUL_DONE;
         end
         MUL_DONE: state_d = MUL_IDLE;
         default:  state_d = MUL_IDLE;
      endcase
      if (abort) state_d = MUL_IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= MUL_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign idle    = (state_q == MUL_IDLE);
   assign busy    = (state_q == MUL_BUSY);
   assign done    = (state_q == MUL_DONE);
   assign product = acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, single-cycle ALU, iterative MULT
// and the EX/MEM pipeline register; stalls upstream while multiplying.
module ex_stage
   import ex_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        flush_in,
   input  logic [31:0] PCNext_in,
   input  logic [31:0] ReadData1_in,
   input  logic [31:0] ReadData2_in,
   input  logic [31:0] im_in,
   input  logic [4:0]  rs_addr_in,
   input  logic [4:0]  rt_addr_in,
   input  logic [3:0]  ALU_control_in,
   input  logic        ReadData1_sel_in,
   input  logic        ReadData2_sel_in,
   input  logic        data_mem_en_in,
   input  logic        wb_data_sel_in,
   input  logic        wb_write_en_in,
   input  logic        wb_addr_sel_in,
   input  logic [4:0]  wb_addr1_in,
   input  logic [4:0]  wb_addr2_in,
   input  logic        fwd_mem_en,
   input  logic [4:0]  fwd_mem_addr,
   input  logic [31:0] fwd_mem_data,
   input  logic        fwd_wb_en,
   input  logic [4:0]  fwd_wb_addr,
   input  logic [31:0] fwd_wb_data,
   output logic [31:0] ALU_result_out,
   output logic [31:0] WriteData_out,
   output logic [4:0]  wb_addr_out,
   output logic        data_mem_en_out,
   output logic        wb_data_sel_out,
   output logic        wb_write_en_out,
   output logic        stall_out
);

   logic [DATA_W-1:0] fwd_a, fwd_b, op_a, op_b;
   logic [DATA_W-1:0] alu_res, product;
   logic [4:0]        shamt;
   logic              mul_req, mul_idle, mul_busy, mul_done;

   logic [DATA_W-1:0] alu_result_q, alu_result_d;
   logic [DATA_W-1:0] write_data_q, write_data_d;
   logic [4:0]        wb_addr_q, wb_addr_d;
   logic              data_mem_en_q, data_mem_en_d;
   logic              wb_data_sel_q, wb_data_sel_d;
   logic              wb_write_en_q, wb_write_en_d;

   assign fwd_a = fwd_pick(rs_addr_in, ReadData1_in,
                           fwd_mem_en, fwd_mem_addr, fwd_mem_data,
                           fwd_wb_en, fwd_wb_addr, fwd_wb_data);
   assign fwd_b = fwd_pick(rt_addr_in, ReadData2_in,
                           fwd_mem_en, fwd_mem_addr, fwd_mem_data,
                           fwd_wb_en, fwd_wb_addr, fwd_wb_data);

   assign op_a    = ReadData1_sel_in ? PCNext_in : fwd_a;
   assign op_b    = ReadData2_sel_in ? im_in : fwd_b;
   assign shamt   = im_in[10:6];
   assign mul_req = (ALU_control_in == ALU_MULT);

   // Flush and reset both cancel a pending or running multiply.
   assign stall_out = !reset && !flush_in &&
                      ((mul_idle && mul_req) || mul_busy);

   ex_stage_mul_iter u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_req),
      .abort   (flush_in),
      .a_in    (op_a),
      .b_in    (op_b),
      .idle    (mul_idle),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (product)
   );

   always_comb begin
      alu_res = '0;
      unique case (ALU_control_in)
         ALU_AND:  alu_res = op_a & op_b;
         ALU_OR:   alu_res = op_a | op_b;
         ALU_ADD:  alu_res = op_a + op_b;
         ALU_SUB:  alu_res = op_a - op_b;
         ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}},
                              $signed(op_a) < $signed(op_b)};
         ALU_NOR:  alu_res = ~(op_a | op_b);
         ALU_XOR:  alu_res = op_a ^ op_b;
         ALU_SLL:  alu_res = op_b << shamt;
         ALU_SRL:  alu_res = op_b >> shamt;
         ALU_SRA:  alu_res = $unsigned($signed(op_b) >>> shamt);
         ALU_MULT: alu_res = mul_done ? product : '0;
         ALU_LUI:  alu_res = op_b << 16;
         default:  alu_res = '0;
      endcase
   end

   always_comb begin
      alu_result_d  = alu_res;
      write_data_d  = fwd_b;
      wb_addr_d     = wb_addr_sel_in ? wb_addr2_in : wb_addr1_in;
      data_mem_en_d = data_mem_en_in;
      wb_data_sel_d = wb_data_sel_in;
      wb_write_en_d = wb_write_en_in;
      if (flush_in || stall_out) begin
         alu_result_d  = '0;
         write_data_d  = '0;
         wb_addr_d     = '0;
         data_mem_en_d = 1'b0;
         wb_data_sel_d = 1'b0;
         wb_write_en_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         alu_result_q  <= '0;
         write_data_q  <= '0;
         wb_addr_q     <= '0;
         data_mem_en_q <= 1'b0;
         wb_data_sel_q <= 1'b0;
         wb_write_en_q <= 1'b0;
      end else begin
         alu_result_q  <= alu_result_d;
         write_data_q  <= write_data_d;
         wb_addr_q     <= wb_addr_d;
         data_mem_en_q <= data_mem_en_d;
         wb_data_sel_q <= wb_data_sel_d;
         wb_write_en_q <= wb_write_en_d;
      end
   end

   assign ALU_result_out  = alu_result_q;
   assign WriteData_out   = write_data_q;
   assign wb_addr_out     = wb_addr_q;
   assign data_mem_en_out = data_mem_en_q;
   assign wb_data_sel_out = wb_data_sel_q;
   assign wb_write_en_out = wb_write_en_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus queues per-cycle expectations,
// a negedge monitor checks stall_out now and EX/MEM after the next edge.
module tb_ex_stage;

   logic        clk = 1'b1;
   logic        reset, flush_in;
   logic [31:0] PCNext_in, ReadData1_in, ReadData2_in, im_in;
   logic [4:0]  rs_addr_in, rt_addr_in;
   logic [3:0]  ALU_control_in;
   logic        ReadData1_sel_in, ReadData2_sel_in;
   logic        data_mem_en_in, wb_data_sel_in;
   logic        wb_write_en_in, wb_addr_sel_in;
   logic [4:0]  wb_addr1_in, wb_addr2_in;
   logic        fwd_mem_en, fwd_wb_en;
   logic [4:0]  fwd_mem_addr, fwd_wb_addr;
   logic [31:0] fwd_mem_data, fwd_wb_data;
   logic [31:0] ALU_result_out, WriteData_out;
   logic [4:0]  wb_addr_out;
   logic        data_mem_en_out, wb_data_sel_out;
   logic        wb_write_en_out, stall_out;

   typedef struct {
      string       nm;
      logic        st;
      logic [31:0] res;
      logic [31:0] wd;
      logic [7:0]  ctl;
   } exp_t;

   // ctl = {wb_addr, data_mem_en, wb_data_sel, wb_write_en}
   localparam logic [7:0] CW = 8'h19;

   exp_t q[$];
   exp_t p;
   bit   have_p = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk(clk), .reset(reset), .flush_in(flush_in),
      .PCNext_in(PCNext_in), .ReadData1_in(ReadData1_in),
      .ReadData2_in(ReadData2_in), .im_in(im_in),
      .rs_addr_in(rs_addr_in), .rt_addr_in(rt_addr_in),
      .ALU_control_in(ALU_control_in),
      .ReadData1_sel_in(ReadData1_sel_in),
      .ReadData2_sel_in(ReadData2_sel_in),
      .data_mem_en_in(data_mem_en_in),
      .wb_data_sel_in(wb_data_sel_in),
      .wb_write_en_in(wb_write_en_in),
      .wb_addr_sel_in(wb_addr_sel_in),
      .wb_addr1_in(wb_addr1_in), .wb_addr2_in(wb_addr2_in),
      .fwd_mem_en(fwd_mem_en), .fwd_mem_addr(fwd_mem_addr),
      .fwd_mem_data(fwd_mem_data),
      .fwd_wb_en(fwd_wb_en), .fwd_wb_addr(fwd_wb_addr),
      .fwd_wb_data(fwd_wb_data),
      .ALU_result_out(ALU_result_out),
      .WriteData_out(WriteData_out),
      .wb_addr_out(wb_addr_out),
      .data_mem_en_out(data_mem_en_out),
      .wb_data_sel_out(wb_data_sel_out),
      .wb_write_en_out(wb_write_en_out),
      .stall_out(stall_out)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (have_p) begin
            chk({p.nm, ".res"}, ALU_result_out, p.res);
            chk({p.nm, ".wd"}, WriteData_out, p.wd);
            chk({p.nm, ".ctl"},
                {24'd0, wb_addr_out, data_mem_en_out,
                 wb_data_sel_out, wb_write_en_out},
                {24'd0, p.ctl});
            have_p = 1'b0;
         end
         if (q.size() > 0) begin
            p = q.pop_front();
            chk({p.nm, ".stall"}, {31'd0, stall_out}, {31'd0, p.st});
            have_p = 1'b1;
         end
      end
   end

   function automatic exp_t mk(input string nm, input logic st,
                               input logic [31:0] res,
                               input logic [31:0] wd,
                               input logic [7:0] ctl);
      exp_t e;
      e.nm = nm; e.st = st; e.res = res; e.wd = wd; e.ctl = ctl;
      return e;
   endfunction

   task automatic clr();
      reset = 0; flush_in = 0;
      PCNext_in = 0; ReadData1_in = 0; ReadData2_in = 0; im_in = 0;
      rs_addr_in = 0; rt_addr_in = 0; ALU_control_in = 0;
      ReadData1_sel_in = 0; ReadData2_sel_in = 0;
      data_mem_en_in = 0; wb_data_sel_in = 0;
      wb_write_en_in = 0; wb_addr_sel_in = 0;
      wb_addr1_in = 0; wb_addr2_in = 0;
      fwd_mem_en = 0; fwd_mem_addr = 0; fwd_mem_data = 0;
      fwd_wb_en = 0; fwd_wb_addr = 0; fwd_wb_data = 0;
   endtask

   task automatic op(input logic [3:0] c, input logic [31:0] a,
                     input logic [31:0] b, input logic bsel,
                     input logic [31:0] im);
      clr();
      ALU_control_in = c;
      ReadData1_in = a; ReadData2_in = b;
      ReadData2_sel_in = bsel; im_in = im;
      rs_addr_in = 5'd1; rt_addr_in = 5'd2;
      wb_write_en_in = 1; wb_addr_sel_in = 1;
      wb_addr1_in = 5'd9; wb_addr2_in = 5'd3;
   endtask

   task automatic issue(input exp_t e);
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clr();
      reset = 1; ALU_control_in = 4'd2; wb_write_en_in = 1;
      ReadData1_in = 32'd5;
      issue(mk("rst0", 0, 0, 0, 0));
      issue(mk("rst1", 0, 0, 0, 0));

      op(2, 5, 7, 0, 0);
      issue(mk("add", 0, 32'd12, 32'd7, CW));

      op(3, 32'h99, 32'h55, 1, 1);
      rs_addr_in = 4; rt_addr_in = 4;
      fwd_mem_en = 1; fwd_mem_addr = 4; fwd_mem_data = 32'h10;
      fwd_wb_en = 1; fwd_wb_addr = 4; fwd_wb_data = 32'h20;
      issue(mk("fwd_mem", 0, 32'h0F, 32'h10, CW));
      fwd_mem_addr = 0;
      issue(mk("fwd_wb", 0, 32'h1F, 32'h20, CW));
      fwd_wb_addr = 0;
      issue(mk("fwd_none", 0, 32'h98, 32'h55, CW));
      fwd_mem_en = 0; fwd_mem_addr = 4; fwd_wb_addr = 4;
      issue(mk("fwd_mem_dis", 0, 32'h1F, 32'h20, CW));

      op(9, 0, 32'h80000000, 0, 32'h100);
      issue(mk("sra", 0, 32'hF8000000, 32'h80000000, CW));
      op(4, 32'hFFFFFFFF, 1, 0, 0);
      issue(mk("slt_neg", 0, 1, 1, CW));
      op(4, 1, 32'hFFFFFFFF, 0, 0);
      issue(mk("slt_pos", 0, 0, 32'hFFFFFFFF, CW));
      op(13, 5, 7, 0, 0);
      issue(mk("op13", 0, 0, 7, CW));
      op(7, 0, 1, 0, 32'h7C0);
      issue(mk("sll", 0, 32'h80000000, 1, CW));
      op(8, 0, 32'h80000000, 0, 32'h100);
      issue(mk("srl", 0, 32'h08000000, 32'h80000000, CW));
      op(11, 0, 0, 1, 32'h1234);
      issue(mk("lui", 0, 32'h12340000, 0, CW));
      op(5, 0, 0, 0, 0);
      issue(mk("nor", 0, 32'hFFFFFFFF, 0, CW));
      op(6, 32'hF0F0, 32'hFF00, 0, 0);
      issue(mk("xor", 0, 32'h0FF0, 32'hFF00, CW));
      op(1, 32'hF0F0, 32'hFF00, 0, 0);
      issue(mk("or", 0, 32'hFFF0, 32'hFF00, CW));
      op(3, 0, 1, 0, 0);
      issue(mk("sub_wrap", 0, 32'hFFFFFFFF, 1, CW));
      op(2, 32'hFFFFFFFF, 1, 0, 0);
      issue(mk("add_wrap", 0, 0, 1, CW));
      op(2, 32'hAAAA, 0, 1, 4);
      ReadData1_sel_in = 1; PCNext_in = 32'h100;
      issue(mk("pc_sel", 0, 32'h104, 0, CW));
      op(0, 32'hF0F0, 32'hFF00, 0, 0);
      data_mem_en_in = 1; wb_data_sel_in = 1; wb_addr_sel_in = 0;
      issue(mk("and_ctl", 0, 32'hF000, 32'hFF00, 8'h4F));
      op(2, 5, 7, 0, 0);
      flush_in = 1;
      issue(mk("flush_add", 0, 0, 0, 0));

      op(10, 32'h10001, 32'h10001, 0, 0);
      issue(mk("mul_start", 1, 0, 0, 0));
      fwd_mem_en = 1; fwd_mem_addr = 1; fwd_mem_data = 32'hDEAD;
      for (int i = 0; i < 32; i++)
         issue(mk("mul_busy", 1, 0, 0, 0));
      issue(mk("mul_done", 0, 32'h00020001, 32'h10001, CW));
      op(2, 1, 2, 0, 0);
      issue(mk("post_mul", 0, 3, 2, CW));

      op(10, 32'hFFFFFFFF, 0, 1, 3);
      issue(mk("mul2_start", 1, 0, 0, 0));
      for (int i = 0; i < 32; i++)
         issue(mk("mul2_busy", 1, 0, 0, 0));
      issue(mk("mul2_done", 0, 32'hFFFFFFFD, 0, CW));

      op(10, 3, 5, 0, 0);
      issue(mk("mulf_start", 1, 0, 0, 0));
      for (int i = 0; i < 9; i++)
         issue(mk("mulf_busy", 1, 0, 0, 0));
      flush_in = 1;
      issue(mk("mul_flush", 0, 0, 0, 0));
      op(2, 2, 2, 0, 0);
      issue(mk("post_flush", 0, 4, 2, CW));

      op(10, 3, 5, 0, 0);
      flush_in = 1;
      issue(mk("flush_start", 0, 0, 0, 0));
      op(2, 2, 3, 0, 0);
      issue(mk("post_fs", 0, 5, 3, CW));

      op(10, 3, 5, 0, 0);
      issue(mk("mulr_start", 1, 0, 0, 0));
      for (int i = 0; i < 5; i++)
         issue(mk("mulr_busy", 1, 0, 0, 0));
      reset = 1;
      issue(mk("mul_rst", 0, 0, 0, 0));
      op(2, 1, 1, 0, 0);
      issue(mk("post_rst", 0, 2, 1, CW));

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
